// File: rtl/fwrisc_arb_pkg.sv
// Shared types and defaults for the boot sequencer / memory arbiter.
package fwrisc_arb_pkg;

    typedef enum logic {LOAD, RUN} boot_state_e;
    typedef enum logic {IDLE, ACC} acc_state_e;
    typedef enum logic {OWN_I, OWN_D} owner_e;

    localparam logic [31:0] DEF_ITCM_BASE = 32'h8000_0000;

    // Byte address of a 32-bit word index relative to a base address.
    function automatic logic [31:0] word_addr(input logic [31:0] base, input logic [31:0] idx);
        return base + (idx << 2);
    endfunction

endpackage

// File: rtl/fwrisc_boot_seq.sv
// Boot sequencer: LOAD/RUN state, loader word counter, overflow flag and
// core reset release. The write itself is issued by the parent.
module fwrisc_boot_seq
    import fwrisc_arb_pkg::*;
#(
    parameter int ITCM_WORDS = 4096,
    localparam int WCNT_W = $clog2(ITCM_WORDS)
) (
    input  logic              clock,
    input  logic              rst_n,
    input  logic              ld_valid_i,
    input  logic              ld_last_i,
    output logic              ld_ready_o,
    output logic              load_we_o,
    output logic [WCNT_W-1:0] wcnt_o,
    output logic              run_o,
    output logic              boot_done_o,
    output logic              core_rst_n_o,
    output logic              ovf_o
);

    localparam logic [WCNT_W-1:0] LAST_IDX = WCNT_W'(ITCM_WORDS - 1);

    boot_state_e       state_q, state_d;
    logic              started_q, started_d;
    logic [WCNT_W-1:0] wcnt_q, wcnt_d;
    logic              ovf_q, ovf_d;
    logic              core_rst_n_q, core_rst_n_d;

    // State registers; started_q keeps the loader idle until the first edge after reset.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= LOAD;
            started_q    <= 1'b0;
            wcnt_q       <= '0;
            ovf_q        <= 1'b0;
            core_rst_n_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            started_q    <= started_d;
            wcnt_q       <= wcnt_d;
            ovf_q        <= ovf_d;
            core_rst_n_q <= core_rst_n_d;
        end
    end

    // Next-state: an end marker wins over a full ITCM, so the last slot is not written then.
    always_comb begin
        state_d      = state_q;
        started_d    = 1'b1;
        wcnt_d       = wcnt_q;
        ovf_d        = ovf_q;
        core_rst_n_d = (state_q == RUN);
        load_we_o    = 1'b0;
        if (state_q == LOAD && started_q && ld_valid_i) begin
            if (ld_last_i) begin
                state_d = RUN;
            end else begin
                load_we_o = 1'b1;
                wcnt_d    = wcnt_q + WCNT_W'(1);
                if (wcnt_q == LAST_IDX) begin
                    state_d = RUN;
                    ovf_d   = 1'b1;
                end
            end
        end
    end

    assign ld_ready_o   = (state_q == LOAD) && started_q;
    assign wcnt_o       = wcnt_q;
    assign run_o        = (state_q == RUN);
    assign boot_done_o  = (state_q == RUN);
    assign core_rst_n_o = core_rst_n_q;
    assign ovf_o        = ovf_q;

endmodule

// File: rtl/fwrisc_mem_arbiter.sv
// Single-port memory owner: boot loader writes during LOAD, then data-priority
// arbitration of core instruction/data accesses with a starvation bound.
module fwrisc_mem_arbiter
    import fwrisc_arb_pkg::*;
#(
    parameter int          ITCM_WORDS   = 4096,
    parameter logic [31:0] ITCM_BASE    = DEF_ITCM_BASE,
    parameter int          STARVE_LIMIT = 4
) (
    input  logic        clock,
    input  logic        rst_n,
    input  logic        ld_valid,
    input  logic [31:0] ld_data,
    input  logic        ld_last,
    output logic        ld_ready,
    input  logic        ivalid,
    input  logic [31:0] iaddr,
    output logic        iready,
    output logic [31:0] idata,
    input  logic        dvalid,
    input  logic [31:0] daddr,
    input  logic [31:0] dwdata,
    input  logic [3:0]  dstrb,
    input  logic        dwrite,
    output logic        dready,
    output logic [31:0] drdata,
    output logic        mem_en,
    output logic [3:0]  mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    output logic        core_rst_n,
    output logic        boot_done,
    output logic        ovf
);

    localparam int WCNT_W = $clog2(ITCM_WORDS);
    localparam int SC_W   = $clog2(STARVE_LIMIT + 1);
    localparam logic [SC_W-1:0] SC_MAX = SC_W'(STARVE_LIMIT);

    logic              load_we;
    logic              run;
    logic [WCNT_W-1:0] wcnt;

    acc_state_e        acc_q, acc_d;
    owner_e            own_q, own_d;
    logic              dwr_q, dwr_d;
    logic [SC_W-1:0]   starve_q, starve_d;
    logic              grant_i, grant_d;

    fwrisc_boot_seq #(
        .ITCM_WORDS (ITCM_WORDS)
    ) u_boot (
        .clock        (clock),
        .rst_n        (rst_n),
        .ld_valid_i   (ld_valid),
        .ld_last_i    (ld_last),
        .ld_ready_o   (ld_ready),
        .load_we_o    (load_we),
        .wcnt_o       (wcnt),
        .run_o        (run),
        .boot_done_o  (boot_done),
        .core_rst_n_o (core_rst_n),
        .ovf_o        (ovf)
    );

    // Access FSM and arbitration state; reset drops any pending ready.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            acc_q    <= IDLE;
            own_q    <= OWN_D;
            dwr_q    <= 1'b0;
            starve_q <= '0;
        end else begin
            acc_q    <= acc_d;
            own_q    <= own_d;
            dwr_q    <= dwr_d;
            starve_q <= starve_d;
        end
    end

    // Memory port drive and arbitration: loader writes in LOAD, core grants in RUN/IDLE.
    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 4'h0;
        mem_addr  = 32'h0;
        mem_wdata = 32'h0;
        acc_d     = acc_q;
        own_d     = own_q;
        dwr_d     = dwr_q;
        starve_d  = starve_q;
        grant_i   = 1'b0;
        grant_d   = 1'b0;
        if (load_we) begin
            mem_en    = 1'b1;
            mem_we    = 4'hF;
            mem_addr  = word_addr(ITCM_BASE, 32'(wcnt));
            mem_wdata = ld_data;
        end else if (run) begin
            case (acc_q)
                IDLE: begin
                    grant_i = ivalid && (!dvalid || starve_q == SC_MAX);
                    grant_d = dvalid && !grant_i;
                    if (!ivalid) begin
                        starve_d = '0;
                    end
                    if (grant_i) begin
                        mem_en   = 1'b1;
                        mem_addr = iaddr;
                        acc_d    = ACC;
                        own_d    = OWN_I;
                        dwr_d    = 1'b0;
                        starve_d = '0;
                    end else if (grant_d) begin
                        mem_en    = 1'b1;
                        mem_addr  = daddr;
                        mem_wdata = dwdata;
                        mem_we    = dwrite ? dstrb : 4'h0;
                        acc_d     = ACC;
                        own_d     = OWN_D;
                        dwr_d     = dwrite;
                        if (ivalid) begin
                            starve_d = starve_q + SC_W'(1);
                        end
                    end
                end
                ACC: begin
                    acc_d = IDLE;
                end
                default: begin
                    acc_d = IDLE;
                end
            endcase
        end
    end

    assign iready = (acc_q == ACC) && (own_q == OWN_I);
    assign dready = (acc_q == ACC) && (own_q == OWN_D);
    assign idata  = iready ? mem_rdata : 32'h0;
    assign drdata = (dready && !dwr_q) ? mem_rdata : 32'h0;

endmodule

// File: tb/tb_fwrisc_mem_arbiter.sv
// Directed bench for fwrisc_mem_arbiter (small ITCM to reach overflow quickly).
module tb_fwrisc_mem_arbiter;

    logic        clock = 1'b0;
    logic        rst_n = 1'b0;
    logic        ld_valid = 1'b0;
    logic [31:0] ld_data = 32'h0;
    logic        ld_last = 1'b0;
    logic        ld_ready;
    logic        ivalid = 1'b0;
    logic [31:0] iaddr = 32'h0;
    logic        iready;
    logic [31:0] idata;
    logic        dvalid = 1'b0;
    logic [31:0] daddr = 32'h0;
    logic [31:0] dwdata = 32'h0;
    logic [3:0]  dstrb = 4'h0;
    logic        dwrite = 1'b0;
    logic        dready;
    logic [31:0] drdata;
    logic        mem_en;
    logic [3:0]  mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = 32'h0;
    logic        core_rst_n;
    logic        boot_done;
    logic        ovf;

    int checks = 0;
    int failures = 0;

    fwrisc_mem_arbiter #(
        .ITCM_WORDS   (8),
        .ITCM_BASE    (32'h8000_0000),
        .STARVE_LIMIT (4)
    ) dut (
        .clock      (clock),
        .rst_n      (rst_n),
        .ld_valid   (ld_valid),
        .ld_data    (ld_data),
        .ld_last    (ld_last),
        .ld_ready   (ld_ready),
        .ivalid     (ivalid),
        .iaddr      (iaddr),
        .iready     (iready),
        .idata      (idata),
        .dvalid     (dvalid),
        .daddr      (daddr),
        .dwdata     (dwdata),
        .dstrb      (dstrb),
        .dwrite     (dwrite),
        .dready     (dready),
        .drdata     (drdata),
        .mem_en     (mem_en),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .core_rst_n (core_rst_n),
        .boot_done  (boot_done),
        .ovf        (ovf)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $display("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
            $error("check %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        int cyc;
        int first_i;
        logic exp_i;

        // Reset state, with clock edges running during reset
        #12;
        check("rst_ld_ready", ld_ready, 0);
        check("rst_mem_en", mem_en, 0);
        check("rst_mem_we", mem_we, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_wdata", mem_wdata, 0);
        check("rst_iready", iready, 0);
        check("rst_dready", dready, 0);
        check("rst_idata", idata, 0);
        check("rst_drdata", drdata, 0);
        check("rst_core_rst_n", core_rst_n, 0);
        check("rst_boot_done", boot_done, 0);
        check("rst_ovf", ovf, 0);
        rst_n = 1'b1;
        #1;
        check("ld_ready_before_edge", ld_ready, 0);
        tick();
        check("ld_ready_after_edge", ld_ready, 1);

        // Load three words then end marker
        ld_valid = 1'b1;
        ld_data  = 32'h11;
        #1;
        check("ld0_en", mem_en, 1);
        check("ld0_we", mem_we, 4'hF);
        check("ld0_addr", mem_addr, 32'h8000_0000);
        check("ld0_wdata", mem_wdata, 32'h11);
        tick();
        ld_data = 32'h22;
        #1;
        check("ld1_addr", mem_addr, 32'h8000_0004);
        check("ld1_wdata", mem_wdata, 32'h22);
        tick();
        ld_data = 32'h33;
        #1;
        check("ld2_addr", mem_addr, 32'h8000_0008);
        check("ld2_wdata", mem_wdata, 32'h33);
        tick();
        ld_last = 1'b1;
        ld_data = 32'h99;
        #1;
        check("last_no_write", mem_en, 0);
        check("last_boot_done_pre", boot_done, 0);
        tick();
        ld_valid = 1'b0;
        ld_last  = 1'b0;
        #1;
        check("run_boot_done", boot_done, 1);
        check("run_ld_ready", ld_ready, 0);
        check("run_core_rst_early", core_rst_n, 0);
        check("run_ovf", ovf, 0);
        tick();
        check("run_core_rst_n", core_rst_n, 1);

        // Data read
        dvalid = 1'b1;
        daddr  = 32'h8000_2000;
        dwrite = 1'b0;
        #1;
        check("dr_en", mem_en, 1);
        check("dr_addr", mem_addr, 32'h8000_2000);
        check("dr_we", mem_we, 0);
        check("dr_ready_early", dready, 0);
        tick();
        mem_rdata = 32'hDEAD_BEEF;
        #1;
        check("dr_ready", dready, 1);
        check("dr_data", drdata, 32'hDEAD_BEEF);
        check("dr_iready", iready, 0);
        check("dr_acc_no_en", mem_en, 0);
        dvalid = 1'b0;
        tick();
        check("dr_single_pulse", dready, 0);

        // Data write with byte strobes
        dvalid = 1'b1;
        dwrite = 1'b1;
        daddr  = 32'h8000_0010;
        dstrb  = 4'b0101;
        dwdata = 32'hAABB_CCDD;
        #1;
        check("dw_en", mem_en, 1);
        check("dw_we", mem_we, 4'b0101);
        check("dw_wdata", mem_wdata, 32'hAABB_CCDD);
        check("dw_addr", mem_addr, 32'h8000_0010);
        tick();
        mem_rdata = 32'h1234_5678;
        #1;
        check("dw_ready", dready, 1);
        check("dw_drdata_zero", drdata, 0);
        dvalid = 1'b0;
        dwrite = 1'b0;
        dstrb  = 4'h0;
        tick();

        // Instruction fetch alone
        ivalid = 1'b1;
        iaddr  = 32'h8000_0004;
        #1;
        check("if_en", mem_en, 1);
        check("if_addr", mem_addr, 32'h8000_0004);
        check("if_we", mem_we, 0);
        tick();
        mem_rdata = 32'hCAFE_F00D;
        #1;
        check("if_iready", iready, 1);
        check("if_idata", idata, 32'hCAFE_F00D);
        check("if_dready", dready, 0);
        ivalid = 1'b0;
        tick();

        // Both requesters held: D,D,D,D,I repeating
        ivalid  = 1'b1;
        iaddr   = 32'h8000_0100;
        dvalid  = 1'b1;
        daddr   = 32'h8000_0200;
        cyc     = 0;
        first_i = -1;
        for (int g = 0; g < 10; g++) begin
            exp_i = ((g % 5) == 4);
            #1;
            check($sformatf("arb%0d_addr", g), mem_addr, exp_i ? 32'h8000_0100 : 32'h8000_0200);
            tick();
            cyc++;
            check($sformatf("arb%0d_iready", g), iready, {31'h0, exp_i});
            check($sformatf("arb%0d_dready", g), dready, {31'h0, !exp_i});
            if (iready && first_i < 0) first_i = cyc;
            if (g == 9) begin
                ivalid = 1'b0;
                dvalid = 1'b0;
            end
            tick();
            cyc++;
        end
        check("starve_wait_bound", (first_i > 0 && first_i <= 10) ? 32'h1 : 32'h0, 32'h1);

        // Asynchronous reset during ACC
        dvalid = 1'b1;
        daddr  = 32'h8000_0300;
        tick();
        check("racc_in_acc", dready, 1);
        rst_n = 1'b0;
        #1;
        check("racc_dready", dready, 0);
        check("racc_drdata", drdata, 0);
        check("racc_boot_done", boot_done, 0);
        check("racc_core_rst_n", core_rst_n, 0);
        check("racc_ld_ready", ld_ready, 0);
        check("racc_mem_en", mem_en, 0);
        dvalid = 1'b0;
        #2;
        rst_n = 1'b1;
        tick();
        check("racc_load_ld_ready", ld_ready, 1);
        check("racc_load_boot_done", boot_done, 0);
        check("racc_no_ready", dready, 0);

        // Fill ITCM without end marker: overflow
        ld_valid = 1'b1;
        for (int k = 0; k < 8; k++) begin
            ld_data = 32'h100 + k;
            #1;
            check($sformatf("ov%0d_en", k), mem_en, 1);
            check($sformatf("ov%0d_addr", k), mem_addr, 32'h8000_0000 + 32'(k * 4));
            check($sformatf("ov%0d_wdata", k), mem_wdata, 32'h100 + k);
            tick();
        end
        ld_valid = 1'b0;
        check("ov_boot_done", boot_done, 1);
        check("ov_flag", ovf, 1);
        check("ov_ld_ready", ld_ready, 0);
        tick();
        check("ov_sticky", ovf, 1);
        check("ov_core_rst_n", core_rst_n, 1);

        // End marker coinciding with last slot: no write, no overflow
        rst_n = 1'b0;
        #1;
        check("rst2_ovf", ovf, 0);
        #2;
        rst_n = 1'b1;
        tick();
        ld_valid = 1'b1;
        for (int k = 0; k < 7; k++) begin
            ld_data = 32'h200 + k;
            tick();
        end
        ld_last = 1'b1;
        #1;
        check("lastfull_no_write", mem_en, 0);
        tick();
        ld_valid = 1'b0;
        ld_last  = 1'b0;
        check("lastfull_boot_done", boot_done, 1);
        check("lastfull_ovf", ovf, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
